instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the program counter.
- Reads the current PC, issues a read to instruction memory, waits for the response and latches the instruction word.
- Presents the instruction to decode through a valid/ready handshake.
- Pulses PCe exactly once per captured instruction so the PC advances.
- Detects memory that never responds by raising a sticky timeout error.

Parameters:
ADDR_W, 16, width of PC and memory address
DATA_W, 16, width of instruction word
TIMEOUT, 16, max cycles mem_rd may stay high without mem_valid before error (legal range 2..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
PC  input  ADDR_W  current program counter from the program counter block
PCe  output  1  one-cycle PC increment enable to the program counter block
mem_addr  output  ADDR_W  instruction memory address
mem_rd  output  1  read request, held high until mem_valid
mem_valid  input  1  memory response valid; mem_rdata is sampled on the same edge
mem_rdata  input  DATA_W  instruction word from memory
flush  input  1  discard current fetch or held instruction
instr  output  DATA_W  latched instruction
instr_valid  output  1  instr holds an unconsumed instruction
instr_ready  input  1  decode accepts instr when instr_valid and instr_ready are both high
fetch_err  output  1  sticky memory timeout flag

Behaviour:
- Reset (async, asserted): state IDLE; PCe, mem_rd, instr_valid and fetch_err = 0; instr = 0; mem_addr = 0; wait counter = 0.
- States: IDLE, FETCH, HOLD, ERR.
- IDLE: all outputs inactive. Goes to FETCH on the first clock edge after reset deasserts, so there is one IDLE cycle.
- FETCH:
  - mem_rd = 1 and mem_addr = PC, both combinational. PC is stable here because PCe is 0.
  - Wait counter increments each FETCH cycle.
  - mem_valid = 1 and flush = 0: at that edge, instr <= mem_rdata, instr_valid <= 1, PCe <= 1 (registered), counter cleared, go to HOLD.
  - flush = 1: no capture and no PCe, regardless of mem_valid. Counter cleared; stay in FETCH, re-requesting the current PC next cycle.
  - Counter reaches TIMEOUT with no mem_valid: fetch_err <= 1, go to ERR.
- HOLD:
  - instr_valid = 1, mem_rd = 0, mem_addr = 0.
  - PCe is high only in the first HOLD cycle. flush in that cycle does not cancel it.
  - instr is stable while instr_valid = 1 and instr_ready = 0.
  - flush = 1: instr_valid <= 0, go to FETCH. flush takes priority over instr_ready.
  - instr_valid = 1 and instr_ready = 1: instr_valid <= 0, go to FETCH. The PC has already advanced, so the next request uses PC+1.
- ERR: mem_rd = 0, PCe = 0, instr_valid = 0, fetch_err = 1. Only reset leaves ERR; flush is ignored.
- Timing: zero-wait memory with instr_ready held at 1 gives one instruction every 2 cycles. With N wait states, mem_rd stays high for N+1 cycles.
- Exactly one PCe pulse per captured instruction. PCe is never asserted in IDLE, FETCH or ERR.
- Reset asserted mid-operation clears everything immediately, including any held instruction and fetch_err.
- No PC wrap logic here; address wrap at 0xFFFF→0x0000 is owned by the program counter.

Test Plan:
- Reset held then released with PC=0x0000 → all outputs 0 during reset; 1 IDLE cycle; then mem_rd=1, mem_addr=0x0000.
- Zero-wait memory returning 0x1000+addr, instr_ready=1, bench PC model increments on PCe → instr sequence 0x1000, 0x1001, …, 0x1009 over 20 cycles; 10 PCe pulses, each exactly 1 cycle wide.
- Memory with 3 wait states → mem_rd high 4 cycles per fetch; instr_valid rises the cycle after mem_valid; a single PCe per instruction.
- instr_ready=0 for 5 cycles after capture of 0xBEEF → instr_valid=1 and instr=0xBEEF stable throughout; mem_rd=0; no second PCe; fetch resumes the cycle after instr_ready=1.
- flush asserted in the same cycle as mem_valid (PC=0x0004) → no capture, no PCe; next cycle mem_rd=1 at 0x0004. flush in HOLD → instr_valid drops next cycle without acceptance.
- mem_valid tied 0, TIMEOUT=16 → fetch_err=1 after 16 FETCH cycles; mem_rd=0 and state frozen despite flush; reset clears fetch_err and fetch restarts.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches the word at PC from instruction memory and hands it to decode,
// pulsing PCe once per captured instruction and trapping in a sticky error on memory timeout.
module instr_fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PC,
  output logic              PCe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fetch_err
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;
  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              pce_q, pce_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    instr_d = instr_q;
    pce_d   = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      // flush outranks both a response and the timeout: the request simply restarts
      FETCH: begin
        if (flush) begin
          state_d = FETCH;
        end else if (mem_valid) begin
          instr_d = mem_rdata;
          pce_d   = 1'b1;
          state_d = HOLD;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: state_d = (flush || instr_ready) ? FETCH : HOLD;
      ERR:  state_d = ERR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      pce_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      pce_q   <= pce_d;
    end
  end
  assign mem_rd      = state_q == FETCH;
  assign mem_addr    = mem_rd ? PC : '0;
  assign instr_valid = state_q == HOLD;
  assign fetch_err   = state_q == ERR;
  assign instr       = instr_q;
  assign PCe         = pce_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized memory/decode environment with a scoreboard of expected
// instruction words, plus directed checks of reset, throughput, stalls and timeout.
module tb_instr_fetch_unit;
  localparam int AW = 16, DW = 16, TO = 16;
  logic clk = 1'b0, reset = 1'b1;
  logic [AW-1:0] PC, mem_addr;
  logic [DW-1:0] mem_rdata, instr;
  logic PCe, mem_rd, mem_valid, flush, instr_valid, instr_ready, fetch_err;
  int n_vec = 0, n_err = 0, n_push = 0, n_pce = 0;
  int waits = 0, p_flush = 0, p_ready = 100, mem_mode = 0;
  bit no_resp = 1'b0;
  logic [DW-1:0] salt = '0;
  logic [AW-1:0] pc_init = '0;
  logic [DW-1:0] exp_q[$];

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .PC(PC), .PCe(PCe), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .flush(flush), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(logic [AW-1:0] a);
    return mem_mode == 0 ? 16'h1000 + a : mem_mode == 1 ? 16'hBEEF : (a * 16'h9E37) ^ salt;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory, PC block and decode model; pushes the expected word whenever a response is accepted
  initial begin
    int wcnt;
    bit pce_s;
    wcnt = 0;
    PC = '0; mem_valid = 1'b0; mem_rdata = '0; flush = 1'b0; instr_ready = 1'b0;
    forever begin
      @(negedge clk);
      pce_s = PCe;
      @(posedge clk);
      #1;
      if (reset) begin
        PC = pc_init; wcnt = 0; exp_q.delete(); n_push = 0;
        mem_valid = 1'b0; flush = 1'b0;
      end else begin
        if (pce_s) PC = PC + 1'b1;
        flush       = $urandom_range(99) < p_flush;
        instr_ready = $urandom_range(99) < p_ready;
        mem_valid   = mem_rd && !no_resp && wcnt >= waits;
        mem_rdata   = mem_valid ? mem_word(PC) : DW'($urandom);
        if (mem_valid && !flush) begin
          exp_q.push_back(mem_word(PC));
          n_push++;
        end
        wcnt = (mem_rd && !mem_valid && !flush) ? wcnt + 1 : 0;
      end
    end
  end

  // monitor: protocol rules from the previous cycle plus scoreboard pops on consumption
  initial begin
    bit pv, pr, pf, prd, pmv;
    logic [DW-1:0] pi;
    pv = 0; pr = 0; pf = 0; prd = 0; pmv = 0; pi = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 0; pr = 0; pf = 0; prd = 0; pmv = 0; n_pce = 0;
      end else begin
        check("pce_first_hold", PCe, instr_valid && !pv);
        if (PCe) n_pce++;
        check("mem_addr", mem_addr, mem_rd ? PC : '0);
        if (fetch_err) check("err_quiet", {mem_rd, instr_valid, PCe}, 0);
        if (instr_valid) check("hold_no_rd", mem_rd, 0);
        if (prd && pf) check("flush_refetch", mem_rd, 1);
        if (prd && pmv && !pf) check("capture", {instr_valid, mem_rd}, 2'b10);
        if (prd && !pmv && !pf && !fetch_err) check("rd_held", mem_rd, 1);
        if (pv) check("hold_exit", instr_valid, !(pf || pr));
        if (pv && !pf && !pr) check("hold_instr", instr, pi);
        if (instr_valid && (flush || instr_ready)) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL instr: got %h expected none at %0t", instr, $time);
          end else check("instr", instr, exp_q.pop_front());
        end
        pv = instr_valid; pr = instr_ready; pf = flush; prd = mem_rd; pmv = mem_valid; pi = instr;
      end
    end
  end

  initial begin
    int n, k;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {PCe, mem_rd, instr_valid, fetch_err}, 0);
    check("rst_instr", instr, 0);
    check("rst_addr", mem_addr, 0);
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    check("idle_cycle", mem_rd, 0);
    @(negedge clk);
    check("first_rd", mem_rd, 1);
    check("first_addr", mem_addr, 0);
    n = 0;
    repeat (20) begin
      if (PCe) n++;
      @(negedge clk);
    end
    check("zero_wait_rate", n, 10);
    waits = 3;
    repeat (10) @(negedge clk);
    n = 0;
    repeat (20) begin
      if (PCe) n++;
      @(negedge clk);
    end
    check("wait3_rate", n, 4);
    waits = 0; mem_mode = 1;
    repeat (10) @(negedge clk);
    p_ready = 0;
    k = 0;
    while (!instr_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("stall_seen", instr_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_hold", {instr_valid, mem_rd, instr}, {2'b10, 16'hBEEF});
      @(negedge clk);
    end
    p_ready = 100;
    @(negedge clk);
    check("stall_accept", instr_valid && instr_ready, 1);
    @(negedge clk);
    check("resume_rd", mem_rd, 1);
    mem_mode = 2; salt = DW'($urandom);
    for (int r = 0; r < 4; r++) begin
      waits = $urandom_range(0, 4); p_flush = $urandom_range(5, 25); p_ready = $urandom_range(40, 100);
      repeat (300) @(negedge clk);
    end
    p_flush = 0; p_ready = 100;
    @(posedge clk); #2 reset = 1'b1;
    no_resp = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 reset = 1'b0;
    n = 0; k = 0;
    while (!fetch_err && k < 60) begin
      @(negedge clk);
      if (mem_rd) n++;
      k++;
    end
    check("timeout_err", fetch_err, 1);
    check("timeout_cycles", n, TO);
    p_flush = 100;
    repeat (5) begin
      @(negedge clk);
      check("err_frozen", {fetch_err, mem_rd, instr_valid, PCe}, 4'b1000);
    end
    p_flush = 0;
    @(posedge clk); #2 reset = 1'b1;
    no_resp = 1'b0; pc_init = 16'hFFF0;
    @(negedge clk);
    check("err_cleared", {fetch_err, instr_valid, mem_rd}, 0);
    @(posedge clk); #2 reset = 1'b0;
    waits = 1; p_flush = 10; p_ready = 70;
    repeat (200) @(negedge clk);
    p_flush = 0; p_ready = 100; waits = 0;
    repeat (4) @(negedge clk);
    k = 0;
    while (!mem_rd && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("drain_rd", mem_rd, 1);
    check("sb_drain", exp_q.size(), mem_valid);
    check("pce_count", n_pce + exp_q.size(), n_push);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
